inst_fetch_buffer: RTL and testbench

//  Consumer side of the PC interface: takes the current fetch address from the PC, issues in-order

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/inst_fetch_buffer_sync_fifo.sv | 61 ++++++
 rtl/inst_fetch_buffer.sv | 124 ++++++++++++
 tb/tb_inst_fetch_buffer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-buffer types and default sizes.
// Imported by the fetch buffer and its FIFO.
package fetch_pkg;

  localparam int FETCH_ADDR_W    = 32;
  localparam int FETCH_INST_W    = 32;
  localparam int FETCH_DEPTH     = 4;
  localparam int FETCH_MAX_OUTST = 2;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] addr;
    logic                    discard;
  } track_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_sync_fifo.sv
// Generic synchronous FIFO with clear, occupancy count and exposed pointers.
// Pointers are exported so callers can keep side-band bits per slot.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  T              din,
  output T              dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr
);

  T mem [DEPTH];

  logic do_push;
  logic do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a full FIFO can still accept when a pop frees the head slot
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: issues in-order imem requests from the PC
// and queues returned {pc, inst} pairs for decode.
module inst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = FETCH_ADDR_W,
  parameter int INST_W    = FETCH_INST_W,
  parameter int DEPTH     = FETCH_DEPTH,
  parameter int MAX_OUTST = FETCH_MAX_OUTST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_enable,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready
);

  localparam int TPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int TCW = $clog2(MAX_OUTST + 1);
  localparam int QPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QCW = $clog2(DEPTH + 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  logic           trk_push, trk_pop, trk_full, trk_empty;
  logic [TCW-1:0] inflight;
  logic [TPW-1:0] trk_rd_ptr, trk_wr_ptr;
  addr_t          trk_addr;
  logic [MAX_OUTST-1:0] discard;

  logic           q_push, q_pop, q_full, q_empty;
  logic [QCW-1:0] q_count;
  logic [QPW-1:0] q_rd_ptr, q_wr_ptr;
  ent_t           q_din, q_head;

  logic can_issue;
  logic rsp_fire;

  assign can_issue = ~trk_full
                   & (int'(q_count) + int'(inflight) < DEPTH);
  assign imem_req  = ~rst & ~flush & can_issue;
  assign imem_addr = pc_addr;
  assign pc_enable = ~rst & ((imem_req & imem_gnt) | flush);

  assign trk_push = imem_req & imem_gnt;
  assign rsp_fire = imem_rvalid & ~trk_empty;
  assign trk_pop  = rsp_fire;

  sync_fifo #(
    .T     (addr_t),
    .DEPTH (MAX_OUTST)
  ) u_tracker (
    .clk    (clk),
    .rst    (rst),
    .push   (trk_push),
    .pop    (trk_pop),
    .clear  (1'b0),
    .din    (pc_addr),
    .dout   (trk_addr),
    .count  (inflight),
    .full   (trk_full),
    .empty  (trk_empty),
    .rd_ptr (trk_rd_ptr),
    .wr_ptr (trk_wr_ptr)
  );

  // stale requests stay tracked so their responses are consumed and dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard <= '0;
    end else if (flush) begin
      discard <= '1;
    end else if (trk_push) begin
      discard[trk_wr_ptr] <= 1'b0;
    end
  end

  assign q_push = rsp_fire & ~discard[trk_rd_ptr] & ~flush;
  assign q_pop  = id_valid & id_ready & ~flush;
  assign q_din  = '{pc: trk_addr, inst: imem_rdata};

  sync_fifo #(
    .T     (ent_t),
    .DEPTH (DEPTH)
  ) u_outq (
    .clk    (clk),
    .rst    (rst),
    .push   (q_push),
    .pop    (q_pop),
    .clear  (flush),
    .din    (q_din),
    .dout   (q_head),
    .count  (q_count),
    .full   (q_full),
    .empty  (q_empty),
    .rd_ptr (q_rd_ptr),
    .wr_ptr (q_wr_ptr)
  );

  assign id_valid = ~q_empty;
  assign id_pc    = id_valid ? q_head.pc   : '0;
  assign id_inst  = id_valid ? q_head.inst : '0;

  logic unused_ok;
  assign unused_ok = ^{q_full, q_rd_ptr, q_wr_ptr};

  a_no_orphan_rsp : assert property (
    @(posedge clk) disable iff (rst) !(imem_rvalid && trk_empty)
  );

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized bench for inst_fetch_buffer against an epoch-based
// memory/decode reference model.
module tb_inst_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_enable;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;

  inst_fetch_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .pc_enable   (pc_enable),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_ready    (id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
    int          ep;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  pend_t       pend[$];
  ent_t        expq[$];
  int          epoch = 0;
  int          cyc = 0;
  logic [31:0] pc_m = 32'h0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic run(input int n, input int p_gnt, input int p_rv,
                     input int p_rdy, input int p_fl);
    logic        e_req;
    logic [31:0] tgt;
    pend_t       h;
    ent_t        e;
    for (int i = 0; i < n; i++) begin
      imem_gnt = ($urandom_range(99) < p_gnt);
      id_ready = ($urandom_range(99) < p_rdy);
      flush    = ($urandom_range(99) < p_fl);
      tgt      = $urandom;
      imem_rvalid = (pend.size() > 0) && (pend[0].rdy <= cyc)
                  && ($urandom_range(99) < p_rv);
      imem_rdata  = imem_rvalid ? inst_of(pend[0].addr) : $urandom;
      pc_addr     = pc_m;
      @(negedge clk);
      e_req = !flush && pend.size() < 2
            && (expq.size() + pend.size() < 4);
      check_eq("imem_req", 32'(imem_req), 32'(e_req));
      check_eq("imem_addr", imem_addr, pc_m);
      check_eq("pc_enable", 32'(pc_enable),
               32'((e_req && imem_gnt) || flush));
      check_eq("id_valid", 32'(id_valid), 32'(expq.size() > 0));
      if (id_valid && id_ready && !flush && expq.size() > 0) begin
        e = expq.pop_front();
        check_eq("id_pc", id_pc, e.pc);
        check_eq("id_inst", id_inst, e.inst);
      end
      if (imem_rvalid) begin
        h = pend.pop_front();
        if (!flush && h.ep == epoch)
          expq.push_back('{pc: h.addr, inst: inst_of(h.addr)});
      end
      if (flush) begin
        expq.delete();
        epoch++;
        pc_m = tgt;
      end else if (e_req && imem_gnt) begin
        pend.push_back('{addr: pc_m, rdy: cyc + $urandom_range(3, 1),
                         ep: epoch});
        pc_m = pc_m + 1;
      end
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    pc_addr     = '0;
    flush       = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    id_ready    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_pc_en", 32'(pc_enable), 32'd0);
    check_eq("rst_id_valid", 32'(id_valid), 32'd0);
    check_eq("rst_id_pc", id_pc, 32'd0);
    check_eq("rst_id_inst", id_inst, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run(40, 100, 100, 100, 0);
    run(20, 100, 100, 0, 0);
    run(20, 100, 100, 30, 0);
    run(30, 40, 50, 100, 0);
    run(200, 70, 60, 70, 10);
    run(150, 60, 70, 60, 30);

    imem_rvalid = 1'b0;
    flush       = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_id_valid", 32'(id_valid), 32'd0);
    check_eq("mid_rst_req", 32'(imem_req), 32'd0);
    check_eq("mid_rst_pc_en", 32'(pc_enable), 32'd0);
    pend.delete();
    expq.delete();
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;

    run(60, 100, 100, 100, 0);
    run(200, 80, 60, 50, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
